// File: rtl/switch_ingress_port_if.sv
// Port-side and arbiter-side signals of one switch ingress port.
// master = packet source + arbiter (environment), slave = the ingress port itself.
interface switch_ingress_port_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_PORTS-1:0]          in_source;
    logic [NUM_PORTS-1:0]          in_target;
    logic [DATA_W-1:0]             in_data;
    logic                          port_req;
    logic [NUM_PORTS-1:0]          req_mask;
    logic [NUM_PORTS-1:0]          grant;
    logic                          out_valid;
    logic [NUM_PORTS-1:0]          out_mask;
    logic [DATA_W+2*NUM_PORTS-1:0] out_data;
    logic [1:0]                    pkt_type;
    logic [15:0]                   drop_cnt;
    logic                          timeout_pulse;

    modport master (
        output in_valid, in_source, in_target, in_data, grant,
        input  in_ready, port_req, req_mask, out_valid, out_mask, out_data,
               pkt_type, drop_cnt, timeout_pulse
    );

    modport slave (
        input  in_valid, in_source, in_target, in_data, grant,
        output in_ready, port_req, req_mask, out_valid, out_mask, out_data,
               pkt_type, drop_cnt, timeout_pulse
    );
endinterface

// File: rtl/switch_ingress_port.sv
// Ingress port: FIFO, head classifier, per-destination request/grant delivery; SWITCH_PORT_TIMEOUT_EN adds ARB_WAIT timeout drop.
// Latency: write -> port_req 3 cycles, grant -> out_valid 1 cycle; backpressure: in_ready = !fifo_full.

module switch_ingress_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    // Full blocks a push even when a pop lands in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module switch_ingress_port #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PORT_ID        = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    switch_ingress_port_if.slave bus
);
    localparam int WORD_W = DATA_W + 2*NUM_PORTS;
    localparam logic [NUM_PORTS-1:0] SELF_MASK = NUM_PORTS'(1) << PORT_ID;
    localparam logic [NUM_PORTS-1:0] BC_MASK   = ~SELF_MASK;
    localparam logic [1:0] T_UC = 2'd0, T_MC = 2'd1, T_BC = 2'd2, T_ERR = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_ARB_WAIT, S_TRANSMIT} state_e;

    state_e               state_q;
    logic [NUM_PORTS-1:0] rem_q;
    logic [1:0]           pkt_type_q;
    logic                 out_valid_q;
    logic [NUM_PORTS-1:0] out_mask_q;
    logic [WORD_W-1:0]    out_data_q;
    logic [15:0]          drop_q;

    logic [WORD_W-1:0]    head_w;
    logic [NUM_PORTS-1:0] head_src;
    logic [NUM_PORTS-1:0] head_tgt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [1:0]           cls;
    logic [NUM_PORTS-1:0] eff_grant;
    logic [NUM_PORTS-1:0] rem_left;
    logic                 route_err;
    logic                 timeout_hit;

    switch_ingress_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.in_valid),
        .pop_i   (fifo_pop),
        .wdata_i ({bus.in_data, bus.in_target, bus.in_source}),
        .rdata_o (head_w),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_src = head_w[NUM_PORTS-1:0];
    assign head_tgt = head_w[2*NUM_PORTS-1:NUM_PORTS];

    always_comb begin
        cls = T_MC;
        if (head_src != SELF_MASK || head_tgt == '0 || head_tgt[PORT_ID])
            cls = T_ERR;
        else if (head_tgt == BC_MASK)
            cls = T_BC;
        else if ((head_tgt & (head_tgt - NUM_PORTS'(1))) == '0)
            cls = T_UC;
    end

    // Grant bits for destinations already served (or never targeted) are ignored.
    assign eff_grant = bus.grant & rem_q;
    assign rem_left  = rem_q & ~eff_grant;
    assign route_err = (state_q == S_ROUTE) && (cls == T_ERR);
    assign fifo_pop  = route_err || timeout_hit ||
                       ((state_q == S_ARB_WAIT) && (eff_grant != '0) && (rem_left == '0));

`ifdef SWITCH_PORT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_q;

    assign timeout_hit = (state_q == S_ARB_WAIT) && (eff_grant == '0) &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   to_cnt_q <= '0;
        else if (state_q != S_ARB_WAIT) to_cnt_q <= '0;
        else if (eff_grant == '0)     to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            pkt_type_q  <= T_ERR;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_data_q  <= '0;
            drop_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if ((route_err || timeout_hit) && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) state_q <= S_ROUTE;
                end
                S_ROUTE: begin
                    pkt_type_q <= cls;
                    if (cls == T_ERR) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q   <= head_tgt;
                        state_q <= S_ARB_WAIT;
                    end
                end
                S_ARB_WAIT: begin
                    if (eff_grant != '0) begin
                        out_valid_q <= 1'b1;
                        out_mask_q  <= eff_grant;
                        out_data_q  <= head_w;
                        rem_q       <= rem_left;
                        state_q     <= S_TRANSMIT;
                    end else if (timeout_hit) begin
                        rem_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_TRANSMIT: begin
                    state_q <= (rem_q == '0) ? S_IDLE : S_ARB_WAIT;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = !fifo_full;
    assign bus.port_req      = (state_q == S_ARB_WAIT);
    assign bus.req_mask      = (state_q == S_ARB_WAIT) ? rem_q : '0;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_mask      = out_mask_q;
    assign bus.out_data      = out_data_q;
    assign bus.pkt_type      = pkt_type_q;
    assign bus.drop_cnt      = drop_q;
    assign bus.timeout_pulse = timeout_hit;
endmodule

// File: tb/tb_switch_ingress_port.sv
// Directed + randomized bench for switch_ingress_port against a queue/rule-based reference model.
module tb_switch_ingress_port;
    localparam int N = 4, W = 8, DEPTH = 4, PID = 0;
    localparam logic [N-1:0] SELF = 4'b0001;
    localparam logic [N-1:0] BCM  = 4'b1110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int drops = 0;

    switch_ingress_port_if #(.NUM_PORTS(N), .DATA_W(W)) bus ();

    switch_ingress_port #(
        .NUM_PORTS(N), .DATA_W(W), .FIFO_DEPTH(DEPTH), .PORT_ID(PID), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference classification straight from the packet rules.
    function automatic logic [1:0] ref_type(input logic [N-1:0] s, input logic [N-1:0] t);
        if (s != SELF || t == '0 || t[PID]) return 2'd3;
        if (t == BCM) return 2'd2;
        if ($countones(t) == 1) return 2'd0;
        return 2'd1;
    endfunction

    task automatic reset_vals(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_port_req"}, bus.port_req, 0);
        check({tag, "_req_mask"}, bus.req_mask, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_mask"}, bus.out_mask, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_pkt_type"}, bus.pkt_type, 3);
        check({tag, "_drop_cnt"}, bus.drop_cnt, 0);
        check({tag, "_timeout"}, bus.timeout_pulse, 0);
    endtask

    task automatic send(input logic [N-1:0] s, input logic [N-1:0] t, input logic [W-1:0] d,
                        output logic acc);
        acc           = bus.in_ready;
        bus.in_valid  = 1'b1;
        bus.in_source = s;
        bus.in_target = t;
        bus.in_data   = d;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 20 && bus.port_req !== 1'b1; k++) tick();
        check(tag, bus.port_req, 1);
    endtask

    // Serves one queued valid packet with random (partly stray) grants until every destination is hit.
    task automatic serve(input logic [N-1:0] tgt, input logic [2*N+W-1:0] word, input logic [1:0] typ);
        logic [N-1:0] rem;
        logic [N-1:0] gr;
        logic [N-1:0] eg;
        rem = tgt;
        wait_req("serve_req");
        check("serve_req_mask", bus.req_mask, rem);
        check("serve_pkt_type", bus.pkt_type, typ);
        for (int guard = 0; guard < 40 && rem != '0; guard++) begin
            gr = (guard >= 30) ? 4'hF : 4'($urandom_range(0, 15));
            bus.grant = gr;
            tick();
            bus.grant = '0;
            eg = gr & rem;
            if (eg != '0) begin
                check("serve_out_valid", bus.out_valid, 1);
                check("serve_out_mask", bus.out_mask, eg);
                check("serve_out_data", bus.out_data, word);
                rem = rem & ~eg;
                if (rem != '0) begin
                    tick();
                    check("serve_rereq", bus.port_req, 1);
                    check("serve_rereq_mask", bus.req_mask, rem);
                end
            end else begin
                check("serve_no_out", bus.out_valid, 0);
                check("serve_still_req", bus.port_req, 1);
            end
        end
        tick();
        check("serve_end_valid", bus.out_valid, 0);
        check("serve_end_req", bus.port_req, 0);
    endtask

    initial begin
        logic acc;
        logic [N-1:0] s;
        logic [N-1:0] t;
        logic [W-1:0] d;
        logic [1:0]   ty;
        logic [2*N+W-1:0] w;
        logic [2*N+W-1:0] q[$];

        bus.in_valid = 1'b0; bus.in_source = '0; bus.in_target = '0;
        bus.in_data = '0; bus.grant = '0;

        tick();
        reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Unicast with exact latency.
        d = 8'hA5;
        send(SELF, 4'b0100, d, acc);
        check("uc_acc", acc, 1);
        check("uc_req_c1", bus.port_req, 0);
        tick();
        check("uc_req_c2", bus.port_req, 0);
        tick();
        check("uc_req_c3", bus.port_req, 1);
        check("uc_mask_c3", bus.req_mask, 4'b0100);
        bus.grant = 4'b0100;
        tick();
        bus.grant = '0;
        check("uc_out_valid", bus.out_valid, 1);
        check("uc_out_mask", bus.out_mask, 4'b0100);
        check("uc_out_data", bus.out_data, {8'hA5, 4'h4, 4'h1});
        check("uc_pkt_type", bus.pkt_type, 0);
        tick();
        check("uc_done_valid", bus.out_valid, 0);
        check("uc_done_req", bus.port_req, 0);

        // Two back-to-back error packets.
        send(SELF, 4'b0001, 8'h11, acc);
        send(4'b0010, 4'b0100, 8'h22, acc);
        drops += 2;
        for (int k = 0; k < 6; k++) begin
            check("err_no_req", bus.port_req, 0);
            tick();
        end
        check("err_drop_cnt", bus.drop_cnt, drops);
        check("err_pkt_type", bus.pkt_type, 3);

        // Multicast over two partial grants.
        send(SELF, 4'b1010, 8'h3C, acc);
        wait_req("mc_req");
        check("mc_mask0", bus.req_mask, 4'b1010);
        bus.grant = 4'b0010;
        tick();
        bus.grant = '0;
        check("mc_out1_valid", bus.out_valid, 1);
        check("mc_out1_mask", bus.out_mask, 4'b0010);
        tick();
        check("mc_mask1", bus.req_mask, 4'b1000);
        check("mc_no_out", bus.out_valid, 0);
        tick();
        bus.grant = 4'b1000;
        tick();
        bus.grant = '0;
        check("mc_out2_valid", bus.out_valid, 1);
        check("mc_out2_mask", bus.out_mask, 4'b1000);
        check("mc_out2_data", bus.out_data, {8'h3C, 4'b1010, SELF});
        check("mc_pkt_type", bus.pkt_type, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("mc_single_pop", bus.port_req, 0);
        end

        // Stray grant bits are ignored.
        send(SELF, 4'b0100, 8'h77, acc);
        wait_req("stray_req");
        bus.grant = 4'b1011;
        tick();
        check("stray_no_out", bus.out_valid, 0);
        check("stray_still_req", bus.port_req, 1);
        check("stray_mask", bus.req_mask, 4'b0100);
        bus.grant = 4'b1111;
        tick();
        bus.grant = '0;
        check("stray_out_valid", bus.out_valid, 1);
        check("stray_out_mask", bus.out_mask, 4'b0100);
        tick();

        // Backpressure: fill with no grants, then drain in order.
        for (int i = 0; i < 5; i++) begin
            t = 4'(4'($urandom_range(1, 7)) << 1);
            d = 8'($urandom);
            send(SELF, t, d, acc);
            check("bp_ready", acc, (q.size() < DEPTH) ? 1 : 0);
            if (q.size() < DEPTH) q.push_back({d, t, SELF});
        end
        check("bp_full", bus.in_ready, 0);
`ifndef SWITCH_PORT_TIMEOUT_EN
        repeat (80) tick();
        check("bp_wait_forever", bus.port_req, 1);
        check("bp_no_timeout", bus.timeout_pulse, 0);
`endif
        while (q.size() > 0) begin
            w = q.pop_front();
            serve(w[7:4], w, ref_type(w[3:0], w[7:4]));
        end
        for (int k = 0; k < 8; k++) begin
            check("bp_fifth_lost", bus.port_req, 0);
            tick();
        end
        check("bp_ready_again", bus.in_ready, 1);

        // Random mix of valid and error packets.
        for (int i = 0; i < 20; i++) begin
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : SELF;
            t  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            ty = ref_type(s, t);
            send(s, t, d, acc);
            check("mix_acc", acc, 1);
            if (ty == 2'd3) begin
                drops++;
                for (int k = 0; k < 4; k++) begin
                    check("mix_err_no_req", bus.port_req, 0);
                    tick();
                end
                check("mix_drop_cnt", bus.drop_cnt, drops);
                check("mix_err_type", bus.pkt_type, 3);
            end else begin
                serve(t, {d, t, s}, ty);
            end
        end

        // Reset while waiting for arbitration with packets queued.
        for (int i = 0; i < 3; i++) send(SELF, 4'b0010, 8'(i), acc);
        wait_req("rst_mid_req");
        rst_n = 1'b0;
        #1;
        reset_vals("rst_mid");
        tick();
        tick();
        rst_n = 1'b1;
        drops = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_no_req", bus.port_req, 0);
            check("post_rst_no_out", bus.out_valid, 0);
        end
        d = 8'h5A;
        send(SELF, BCM, d, acc);
        serve(BCM, {d, BCM, SELF}, 2'd2);
        check("post_rst_drop_cnt", bus.drop_cnt, drops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
